sop_share_sequencer: RTL and testbench

SOP_SHARE_SEQUENCER -- requirements
Module: sop_share_sequencer

---
 rtl/sop_share_sequencer.sv | 143 ++++++++++++++
 tb/tb_sop_share_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sop_share_sequencer.sv
// Time-multiplexed sum-of-products evaluator: one shared product term per cycle,
// ORed into every output that selects it, with a valid/ready result handshake.
module sop_share_sequencer #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 2,
    parameter int N_PR  = 6,
    localparam int IDX_MAX = (N_PR > N_OUT) ? N_PR : N_OUT,
    localparam int IDX_W   = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1,
    localparam int DATA_W  = (2 * N_IN > N_PR + 1) ? 2 * N_IN : N_PR + 1,
    localparam int CNT_W   = (N_PR > 1) ? $clog2(N_PR) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cfg_we_i,
    input  logic              cfg_sel_i,
    input  logic [IDX_W-1:0]  cfg_idx_i,
    input  logic [DATA_W-1:0] cfg_data_i,
    output logic              cfg_busy_o,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [N_IN-1:0]   in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [N_OUT-1:0]  out_data_o
);

    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

    state_t             state_q;
    logic [N_IN-1:0]    x_q;
    logic [N_OUT-1:0]   acc_q;
    logic [N_OUT-1:0]   acc_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               out_valid_q;
    logic [N_OUT-1:0]   out_data_q;
    logic               in_ready_q;
    logic               cfg_busy_q;

    logic [N_IN-1:0]    prod_pos_q [N_PR];
    logic [N_IN-1:0]    prod_neg_q [N_PR];
    logic [N_PR-1:0]    out_sel_q  [N_OUT];
    logic [N_OUT-1:0]   out_en_q;

    logic [N_IN-1:0]    cur_pos;
    logic [N_IN-1:0]    cur_neg;
    logic [N_OUT-1:0]   cur_col;
    logic               prod_hit;

    // Mux out the product term addressed by the counter and the column of
    // output selects that consume it.
    always_comb begin
        cur_pos = '0;
        cur_neg = '0;
        cur_col = '0;
        for (int p = 0; p < N_PR; p++) begin
            if (int'(cnt_q) == p) begin
                cur_pos = prod_pos_q[p];
                cur_neg = prod_neg_q[p];
                for (int o = 0; o < N_OUT; o++) begin
                    cur_col[o] = out_sel_q[o][p];
                end
            end
        end
        prod_hit = &((~cur_pos | x_q) & (~cur_neg | ~x_q));
        acc_d    = acc_q | (cur_col & {N_OUT{prod_hit}});
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            x_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b1;
            cfg_busy_q  <= 1'b0;
            out_en_q    <= '0;
            for (int p = 0; p < N_PR; p++) begin
                prod_pos_q[p] <= '0;
                prod_neg_q[p] <= '0;
            end
            for (int o = 0; o < N_OUT; o++) begin
                out_sel_q[o] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    // Out-of-range indices match no entry and are dropped.
                    if (cfg_we_i) begin
                        if (!cfg_sel_i) begin
                            for (int p = 0; p < N_PR; p++) begin
                                if (int'(cfg_idx_i) == p) begin
                                    prod_pos_q[p] <= cfg_data_i[N_IN-1:0];
                                    prod_neg_q[p] <= cfg_data_i[2*N_IN-1:N_IN];
                                end
                            end
                        end else begin
                            for (int o = 0; o < N_OUT; o++) begin
                                if (int'(cfg_idx_i) == o) begin
                                    out_sel_q[o] <= cfg_data_i[N_PR-1:0];
                                    out_en_q[o]  <= cfg_data_i[N_PR];
                                end
                            end
                        end
                    end
                    if (in_valid_i) begin
                        x_q        <= in_data_i;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        cfg_busy_q <= 1'b1;
                        state_q    <= EVAL;
                    end
                end
                EVAL: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (int'(cnt_q) == N_PR - 1) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= acc_d & out_en_q;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        cfg_busy_q  <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cfg_busy_o  = cfg_busy_q;
    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;

endmodule

// File: tb/tb_sop_share_sequencer.sv
// Bench for sop_share_sequencer: directed scenarios plus randomized configs,
// checked against a product/OR reference model of the configured function.
module tb_sop_share_sequencer;

    localparam int N_IN  = 4;
    localparam int N_OUT = 2;
    localparam int N_PR  = 6;
    localparam int LAT   = N_PR + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_we = 1'b0;
    logic       cfg_sel = 1'b0;
    logic [2:0] cfg_idx = '0;
    logic [7:0] cfg_data = '0;
    logic       cfg_busy;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [1:0] out_data;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] pos_m [N_PR];
    logic [3:0] neg_m [N_PR];
    logic [5:0] sel_m [N_OUT];
    logic [1:0] en_m;

    sop_share_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .N_PR(N_PR)) dut (
        .clk_i(clk), .rst_i(rst),
        .cfg_we_i(cfg_we), .cfg_sel_i(cfg_sel), .cfg_idx_i(cfg_idx),
        .cfg_data_i(cfg_data), .cfg_busy_o(cfg_busy),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    function automatic logic [1:0] model_eval(input logic [3:0] x);
        logic [1:0] res;
        logic       any, prod;
        res = '0;
        for (int o = 0; o < N_OUT; o++) begin
            any = 1'b0;
            for (int p = 0; p < N_PR; p++) begin
                if (sel_m[o][p]) begin
                    prod = 1'b1;
                    for (int i = 0; i < N_IN; i++) begin
                        if (pos_m[p][i] && !x[i]) prod = 1'b0;
                        if (neg_m[p][i] && x[i])  prod = 1'b0;
                    end
                    any = any | prod;
                end
            end
            res[o] = en_m[o] & any;
        end
        return res;
    endfunction

    task automatic model_clear();
        for (int p = 0; p < N_PR; p++) begin pos_m[p] = '0; neg_m[p] = '0; end
        for (int o = 0; o < N_OUT; o++) sel_m[o] = '0;
        en_m = '0;
    endtask

    task automatic model_write(input bit s, input int idx, input logic [7:0] d);
        if (!s && idx < N_PR) begin
            pos_m[idx] = d[3:0];
            neg_m[idx] = d[7:4];
        end else if (s && idx < N_OUT) begin
            sel_m[idx] = d[5:0];
            en_m[idx]  = d[6];
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic cfg_write(input bit s, input int idx, input logic [7:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_sel = s; cfg_idx = 3'(idx); cfg_data = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        model_write(s, idx, d);
    endtask

    // Accept one operand and wait (bounded) for out_valid; optionally complete the handshake.
    task automatic op(input logic [3:0] x, input bit rel, output logic [1:0] got, output int lat);
        @(negedge clk);
        in_valid = 1'b1; in_data = x;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        got = out_data;
        if (rel) begin
            @(negedge clk); out_ready = 1'b1;
            @(posedge clk); #1; out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (out_data !== 2'b00) begin n_err++; $display("FAIL reset_out_data got=%b exp=00", out_data); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_cmp++; if (cfg_busy !== 1'b0) begin n_err++; $display("FAIL reset_cfg_busy got=%b exp=0", cfg_busy); end
    endtask

    task automatic test_unconfigured();
        logic [1:0] got; int lat;
        op(4'b1010, 1'b1, got, lat);
        n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL unconf_latency got=%0d exp=%0d", lat, LAT); end
        n_cmp++; if (got !== 2'b00) begin n_err++; $display("FAIL unconf_data got=%b exp=00", got); end
    endtask

    task automatic test_shared_or();
        logic [1:0] got; int lat;
        cfg_write(0, 0, 8'h08);
        cfg_write(0, 1, 8'h02);
        cfg_write(0, 2, 8'h20);
        cfg_write(0, 3, 8'h01);
        cfg_write(0, 4, 8'h10);
        cfg_write(0, 5, 8'h00);
        cfg_write(1, 1, 8'h5F);
        cfg_write(1, 0, 8'h00);
        for (int x = 0; x < 16; x++) begin
            op(4'(x), 1'b1, got, lat);
            n_cmp++; if (got !== 2'b10) begin n_err++; $display("FAIL shared_or x=%0d got=%b exp=10", x, got); end
            n_cmp++; if (got !== model_eval(4'(x))) begin n_err++; $display("FAIL shared_or_model x=%0d got=%b exp=%b", x, got, model_eval(4'(x))); end
        end
    endtask

    task automatic test_single_product();
        logic [1:0] got; int lat;
        do_reset();
        cfg_write(0, 0, 8'hC3);
        cfg_write(1, 0, 8'h41);
        op(4'b0011, 1'b1, got, lat);
        n_cmp++; if (got[0] !== 1'b1) begin n_err++; $display("FAIL single_0011 got=%b exp=1", got[0]); end
        op(4'b0111, 1'b1, got, lat);
        n_cmp++; if (got[0] !== 1'b0) begin n_err++; $display("FAIL single_0111 got=%b exp=0", got[0]); end
    endtask

    task automatic test_random();
        logic [1:0] got; int lat;
        logic [3:0] x;
        for (int it = 0; it < 40; it++) begin
            for (int w = 0; w < int'($urandom_range(3, 0)); w++) begin
                cfg_write(1'($urandom_range(1, 0)), int'($urandom_range(7, 0)), 8'($urandom));
            end
            x = 4'($urandom);
            op(x, 1'b1, got, lat);
            n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL rand_latency it=%0d got=%0d exp=%0d", it, lat, LAT); end
            n_cmp++; if (got !== model_eval(x)) begin n_err++; $display("FAIL rand_data it=%0d x=%h got=%b exp=%b", it, x, got, model_eval(x)); end
        end
    endtask

    task automatic test_hold_done();
        logic [1:0] got, exp_d; int lat;
        do_reset();
        cfg_write(0, 0, 8'h01);
        cfg_write(0, 1, 8'h20);
        cfg_write(1, 0, 8'h41);
        cfg_write(1, 1, 8'h42);
        exp_d = model_eval(4'b0001);
        op(4'b0001, 1'b0, got, lat);
        n_cmp++; if (got !== exp_d) begin n_err++; $display("FAIL hold_first got=%b exp=%b", got, exp_d); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = c[0]; in_data = 4'b1110;
            cfg_we = ~c[0]; cfg_sel = 1'b0; cfg_idx = 3'd0; cfg_data = 8'h10;
            @(posedge clk); #1;
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL hold_valid c=%0d got=%b exp=1", c, out_valid); end
            n_cmp++; if (out_data !== exp_d) begin n_err++; $display("FAIL hold_data c=%0d got=%b exp=%b", c, out_data, exp_d); end
            n_cmp++; if (in_ready !== 1'b0 || cfg_busy !== 1'b1) begin n_err++; $display("FAIL hold_status c=%0d got=%b%b exp=01", c, in_ready, cfg_busy); end
        end
        @(negedge clk);
        in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL hold_release_ready got=%b exp=1", in_ready); end
        op(4'b0001, 1'b1, got, lat);
        n_cmp++; if (got !== model_eval(4'b0001)) begin n_err++; $display("FAIL hold_cfg_kept got=%b exp=%b", got, model_eval(4'b0001)); end
    endtask

    task automatic test_reset_abort();
        logic [1:0] got; int lat; int seen;
        do_reset();
        cfg_write(1, 0, 8'h41);
        cfg_write(1, 1, 8'h41);
        @(negedge clk); in_valid = 1'b1; in_data = 4'b0101;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b0;
        model_clear();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL abort_in_ready got=%b exp=1", in_ready); end
        n_cmp++; if (cfg_busy !== 1'b0) begin n_err++; $display("FAIL abort_cfg_busy got=%b exp=0", cfg_busy); end
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL abort_no_valid got=%0d exp=0", seen); end
        op(4'b0101, 1'b1, got, lat);
        n_cmp++; if (got !== 2'b00) begin n_err++; $display("FAIL abort_cfg_cleared got=%b exp=00", got); end
        // Reset while parked in DONE.
        cfg_write(1, 1, 8'h41);
        op(4'b0000, 1'b0, got, lat);
        n_cmp++; if (got !== 2'b10) begin n_err++; $display("FAIL done_pre got=%b exp=10", got); end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b0;
        model_clear();
        n_cmp++; if (out_valid !== 1'b0 || out_data !== 2'b00) begin n_err++; $display("FAIL done_abort got=%b/%b exp=0/00", out_valid, out_data); end
    endtask

    task automatic test_cfg_drop_and_same_cycle();
        logic [1:0] got; int lat;
        do_reset();
        cfg_write(1, 0, 8'h41);
        cfg_write(1, 1, 8'h42);
        cfg_write(0, 7, 8'h0F);
        cfg_write(1, 2, 8'h00);
        cfg_write(1, 3, 8'h00);
        op(4'b0000, 1'b1, got, lat);
        n_cmp++; if (got !== 2'b11) begin n_err++; $display("FAIL drop_idx got=%b exp=11", got); end
        @(negedge clk);
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_idx = 3'd0; cfg_data = 8'h01;
        in_valid = 1'b1; in_data = 4'b0000;
        @(posedge clk); #1;
        cfg_we = 1'b0; in_valid = 1'b0;
        model_write(0, 0, 8'h01);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
        n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL same_cycle_latency got=%0d exp=%0d", lat, LAT); end
        n_cmp++; if (out_data !== 2'b10 || out_data !== model_eval(4'b0000)) begin n_err++; $display("FAIL same_cycle_data got=%b exp=10", out_data); end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int t_valid [$];
        logic [1:0] exp_d;
        exp_d = model_eval(4'b1001);
        @(negedge clk);
        in_valid = 1'b1; in_data = 4'b1001; out_ready = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) begin
                t_valid.push_back(c);
                n_cmp++; if (out_data !== exp_d) begin n_err++; $display("FAIL b2b_data c=%0d got=%b exp=%b", c, out_data, exp_d); end
            end
        end
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b0;
        n_cmp++; if (t_valid.size() < 4) begin n_err++; $display("FAIL b2b_count got=%0d exp>=4", t_valid.size()); end
        else begin
            n_cmp++; if (t_valid[0] !== LAT) begin n_err++; $display("FAIL b2b_first got=%0d exp=%0d", t_valid[0], LAT); end
            for (int k = 1; k < t_valid.size(); k++) begin
                n_cmp++; if (t_valid[k] - t_valid[k-1] !== N_PR + 2) begin n_err++; $display("FAIL b2b_interval k=%0d got=%0d exp=%0d", k, t_valid[k] - t_valid[k-1], N_PR + 2); end
            end
        end
        repeat (12) @(posedge clk);
    endtask

    initial begin
        model_clear();
        test_reset();
        test_unconfigured();
        test_shared_or();
        test_single_product();
        test_random();
        test_hold_done();
        test_reset_abort();
        test_cfg_drop_and_same_cycle();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
